// File: rtl/mem_responder.sv
// Memory-side responder: word-addressed RAM behind an IDLE/WAIT/RESP FSM with
// programmable wait states, a one-cycle ack and error responses.
module mem_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_LOG2   = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [1:0]        rw,
  input  logic [31:0]       addressbus,
  input  logic [DATA_W-1:0] dout,
  output logic [DATA_W-1:0] din,
  output logic              ack,
  output logic              err,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  // Handshake: a command is taken at a rising edge where req_valid=1, rw!=00 and
  // busy=0; it completes with a single ack cycle (err qualified by ack) and busy
  // falls on the edge that ends ack. Requests while busy=1 are dropped, not queued.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int DEPTH = 2 ** ADDR_LOG2;
  // One cycle more than WAIT_STATES: the access edge itself follows the count.
  localparam logic [4:0] WAIT_LOAD = 5'(WAIT_STATES + 1);

  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  state_t                 state;
  logic [4:0]             cnt;
  logic [1:0]             rw_q;
  logic [31:0]            addr_q;
  logic [DATA_W-1:0]      data_q;
  logic [DATA_W-1:0]      ram [DEPTH];

  logic                   bad;
  logic                   access;
  logic                   ram_we;
  logic [ADDR_LOG2-1:0]   widx;

  assign bad       = (rw_q == OP_RSVD) || (addr_q[31:ADDR_LOG2] != '0);
  assign access    = (state == S_WAIT) && (cnt == 5'd0);
  assign ram_we    = access && !bad && (rw_q == OP_WRITE);
  assign widx      = addr_q[ADDR_LOG2-1:0];
  assign state_dbg = state;

  // No reset on the array: an async reset drops state to IDLE, which kills ram_we.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[widx] <= data_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= 5'd0;
      rw_q   <= 2'b00;
      addr_q <= 32'd0;
      data_q <= '0;
      din    <= '0;
      ack    <= 1'b0;
      err    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && (rw != 2'b00)) begin
            rw_q   <= rw;
            addr_q <= addressbus;
            data_q <= dout;
            cnt    <= WAIT_LOAD;
            busy   <= 1'b1;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == 5'd0) begin
            ack   <= 1'b1;
            err   <= bad;
            state <= S_RESP;
            if ((rw_q == OP_READ) && !bad) begin
              din <= ram[widx];
            end
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        S_RESP: begin
          ack   <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          ack   <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (WAIT_STATES 0, 1, 3) driven by a
// vector table, hand sequences for reset/busy corners and a random phase.
module tb_mem_responder;

  logic        clk;
  logic        reset;
  logic [2:0]  req_v;
  logic [1:0]  rw;
  logic [31:0] addressbus;
  logic [31:0] dout;
  logic [31:0] din_o   [3];
  logic        ack_o   [3];
  logic        err_o   [3];
  logic        busy_o  [3];
  logic [1:0]  st_o    [3];

  int checks = 0;
  int errors = 0;

  // Reference model: per-instance memory contents and last read data.
  logic [31:0] mem_m [int];
  logic [31:0] din_m [3];

  mem_responder #(.DATA_W(32), .ADDR_LOG2(8), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(reset), .req_valid(req_v[0]), .rw(rw), .addressbus(addressbus),
    .dout(dout), .din(din_o[0]), .ack(ack_o[0]), .err(err_o[0]), .busy(busy_o[0]),
    .state_dbg(st_o[0]));

  mem_responder #(.DATA_W(32), .ADDR_LOG2(8), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .reset(reset), .req_valid(req_v[1]), .rw(rw), .addressbus(addressbus),
    .dout(dout), .din(din_o[1]), .ack(ack_o[1]), .err(err_o[1]), .busy(busy_o[1]),
    .state_dbg(st_o[1]));

  mem_responder #(.DATA_W(32), .ADDR_LOG2(8), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset(reset), .req_valid(req_v[2]), .rw(rw), .addressbus(addressbus),
    .dout(dout), .din(din_o[2]), .ack(ack_o[2]), .err(err_o[2]), .busy(busy_o[2]),
    .state_dbg(st_o[2]));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int ws_of(input int idx);
    return (idx == 0) ? 0 : (idx == 1) ? 1 : 3;
  endfunction

  function automatic bit in_range(input logic [31:0] addr);
    return addr[31:8] == 24'd0;
  endfunction

  function automatic int key_of(input int idx, input logic [31:0] addr);
    return idx * 256 + int'(addr[7:0]);
  endfunction

  function automatic logic exp_err_of(input logic [1:0] op, input logic [31:0] addr);
    return (op == 2'b11) || !in_range(addr);
  endfunction

  function automatic logic [31:0] exp_din_of(input int idx, input logic [1:0] op,
                                             input logic [31:0] addr);
    if (op == 2'b01 && in_range(addr) && mem_m.exists(key_of(idx, addr)))
      return mem_m[key_of(idx, addr)];
    return din_m[idx];
  endfunction

  task automatic model_update(input int idx, input logic [1:0] op, input logic [31:0] addr,
                              input logic [31:0] data);
    if (op == 2'b10 && in_range(addr)) mem_m[key_of(idx, addr)] = data;
    if (op == 2'b01 && in_range(addr) && mem_m.exists(key_of(idx, addr)))
      din_m[idx] = mem_m[key_of(idx, addr)];
  endtask

  // driver: one command, checked cycle by cycle from acceptance to busy release
  task automatic run_cmd(input int idx, input logic [1:0] op, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] exp_din,
                         input logic exp_err, input bit spurious, input string tag);
    int ws;
    ws = ws_of(idx);
    @(negedge clk);
    rw = op; addressbus = addr; dout = data;
    req_v = 3'b000; req_v[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_v = 3'b000;
    rw = 2'($urandom); addressbus = $urandom; dout = $urandom;
    for (int k = 0; k <= 3 + ws; k++) begin
      if (spurious && k == 1) begin
        rw = 2'b10; addressbus = 32'h0000_00FF; dout = 32'h0000_0BAD; req_v[idx] = 1'b1;
      end
      if (spurious && k == 2) req_v = 3'b000;
      chk($sformatf("%s ack k=%0d", tag, k), 32'(ack_o[idx]), 32'(k == 2 + ws));
      chk($sformatf("%s busy k=%0d", tag, k), 32'(busy_o[idx]), 32'(k <= 2 + ws));
      if (k == 2 + ws) begin
        chk($sformatf("%s err", tag), 32'(err_o[idx]), 32'(exp_err));
        chk($sformatf("%s din", tag), din_o[idx], exp_din);
      end else begin
        chk($sformatf("%s err idle k=%0d", tag, k), 32'(err_o[idx]), 32'd0);
      end
      if (k < 3 + ws) @(negedge clk);
    end
    req_v = 3'b000;
  endtask

  task automatic do_cmd(input int idx, input logic [1:0] op, input logic [31:0] addr,
                        input logic [31:0] data, input bit spurious, input string tag);
    run_cmd(idx, op, addr, data, exp_din_of(idx, op, addr), exp_err_of(op, addr),
            spurious, tag);
    model_update(idx, op, addr, data);
  endtask

  typedef struct {
    int          idx;
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_din;
    logic        exp_err;
  } vec_t;

  vec_t vecs [12];

  logic [31:0] pool [5];

  initial begin
    vecs[0]  = '{1, 2'b10, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1, 2'b01, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1, 2'b01, 32'h0000_0100, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1};
    vecs[3]  = '{1, 2'b10, 32'h0000_0000, 32'h1111_1111, 32'hDEAD_BEEF, 1'b0};
    vecs[4]  = '{1, 2'b10, 32'h0000_0100, 32'h2222_2222, 32'hDEAD_BEEF, 1'b1};
    vecs[5]  = '{1, 2'b01, 32'h0000_0000, 32'h0000_0000, 32'h1111_1111, 1'b0};
    vecs[6]  = '{1, 2'b11, 32'h0000_0020, 32'h3333_3333, 32'h1111_1111, 1'b1};
    vecs[7]  = '{0, 2'b10, 32'h0000_0007, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
    vecs[8]  = '{0, 2'b01, 32'h0000_0007, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
    vecs[9]  = '{2, 2'b10, 32'h0000_00FF, 32'h0BAD_C0DE, 32'h0000_0000, 1'b0};
    vecs[10] = '{2, 2'b01, 32'h0000_00FF, 32'h0000_0000, 32'h0BAD_C0DE, 1'b0};
    vecs[11] = '{2, 2'b01, 32'h0000_01FF, 32'h0000_0000, 32'h0BAD_C0DE, 1'b1};
    pool[0] = 32'h03; pool[1] = 32'h10; pool[2] = 32'h44; pool[3] = 32'h80; pool[4] = 32'hFF;

    reset = 1'b0; req_v = 3'b000; rw = 2'b00; addressbus = 32'd0; dout = 32'd0;
    for (int i = 0; i < 3; i++) din_m[i] = 32'd0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset ack[%0d]", i), 32'(ack_o[i]), 32'd0);
      chk($sformatf("reset err[%0d]", i), 32'(err_o[i]), 32'd0);
      chk($sformatf("reset busy[%0d]", i), 32'(busy_o[i]), 32'd0);
      chk($sformatf("reset din[%0d]", i), din_o[i], 32'd0);
    end
    reset = 1'b1;

    // vector table
    for (int i = 0; i < 12; i++) begin
      run_cmd(vecs[i].idx, vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].exp_din,
              vecs[i].exp_err, 1'b0, $sformatf("vec%0d", i));
      model_update(vecs[i].idx, vecs[i].op, vecs[i].addr, vecs[i].data);
    end

    // idle opcode with req_valid: never accepted
    @(negedge clk);
    rw = 2'b00; addressbus = 32'h10; req_v = 3'b111;
    @(negedge clk);
    req_v = 3'b000;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("idle-op busy[%0d] k=%0d", i, k), 32'(busy_o[i]), 32'd0);
        chk($sformatf("idle-op ack[%0d] k=%0d", i, k), 32'(ack_o[i]), 32'd0);
      end
      @(negedge clk);
    end

    // second request during WAIT is dropped; back-to-back reads in order
    do_cmd(1, 2'b10, 32'h00, 32'hA0A0_A0A0, 1'b0, "pre0");
    do_cmd(1, 2'b10, 32'hFF, 32'hF0F0_F0F0, 1'b0, "preff");
    do_cmd(1, 2'b10, 32'h00, 32'h1212_1212, 1'b1, "spur");
    do_cmd(1, 2'b01, 32'h00, 32'h0, 1'b0, "rd0");
    do_cmd(1, 2'b01, 32'hFF, 32'h0, 1'b0, "rdff");

    // reset mid-WAIT drops an uncommitted write
    do_cmd(1, 2'b10, 32'h05, 32'h0000_0055, 1'b0, "w5");
    @(negedge clk);
    rw = 2'b10; addressbus = 32'h05; dout = 32'h0000_00AA; req_v = 3'b010;
    @(posedge clk);
    @(negedge clk);
    req_v = 3'b000;
    @(negedge clk);
    chk("midwait busy before reset", 32'(busy_o[1]), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort ack", 32'(ack_o[1]), 32'd0);
    chk("abort busy", 32'(busy_o[1]), 32'd0);
    chk("abort din", din_o[1], 32'd0);
    chk("abort err", 32'(err_o[1]), 32'd0);
    for (int i = 0; i < 3; i++) din_m[i] = 32'd0;
    @(negedge clk);
    reset = 1'b1;
    do_cmd(1, 2'b01, 32'h05, 32'h0, 1'b0, "rd5");

    // randomized phase against the model
    for (int i = 0; i < 3; i++)
      for (int p = 0; p < 5; p++)
        do_cmd(i, 2'b10, pool[p], $urandom, 1'b0, $sformatf("fill%0d_%0d", i, p));
    for (int n = 0; n < 40; n++) begin
      int idx;
      int kind;
      logic [1:0]  op;
      logic [31:0] addr;
      idx  = $urandom_range(0, 2);
      kind = $urandom_range(0, 3);
      addr = pool[$urandom_range(0, 4)];
      case (kind)
        0: op = 2'b01;
        1: op = 2'b10;
        2: op = 2'b11;
        default: begin
          op   = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
          addr = (32'($urandom_range(1, 24'hFF_FFFF)) << 8) | 32'($urandom_range(0, 255));
        end
      endcase
      do_cmd(idx, op, addr, $urandom, 1'b0, $sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
